// File: rtl/m_qsr_drive_pkg.sv
// Shared types and constants for the QSR latch driver.
// State encoding, strobe polarity and counter width.
package m_qsr_drive_pkg;

   localparam int CW = 4;

   localparam logic STROBE_ON  = 1'b0;
   localparam logic STROBE_OFF = 1'b1;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      PRE,
      PULSE,
      POST,
      VERIFY
   } state_t;

endpackage

// File: rtl/m_sync2.sv
// Two-flop synchroniser, async active-low reset to 0.
// Ports: i_clk, i_rst_n, i_d (async in), o_q (synchronised out).
module m_sync2 (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_q    <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/m_qsr_drive.sv
// Driver for a cross-coupled NAND set/reset latch: turns a level request
// into registered, mutually exclusive active-low set/reset strobes with
// minimum width and dead time, then confirms the latch Q via readback.
// Ports: clock, resetl (async active-low), req (desired level),
//        q_in (latch Q readback), s_l/r_l (active-low strobes),
//        busy (not IDLE), done (completion pulse), err (sticky timeout).
module m_qsr_drive
   import m_qsr_drive_pkg::*;
#(
   parameter int PW   = 2,
   parameter int DEAD = 1,
   parameter int TMO  = 4
) (
   input  logic clock,
   input  logic resetl,
   input  logic req,
   input  logic q_in,
   output logic s_l,
   output logic r_l,
   output logic busy,
   output logic done,
   output logic err
);

   // Terminal counts: counter starts at 0 on every state entry.
   localparam logic [CW-1:0] C_PW   = CW'(PW - 1);
   localparam logic [CW-1:0] C_DEAD = CW'(DEAD - 1);
   localparam logic [CW-1:0] C_TMO  = CW'(TMO - 1);

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_cur;
   logic          r_tgt;
   logic          r_init;
   logic          r_s_l;
   logic          r_r_l;
   logic          r_busy;
   logic          r_done;
   logic          r_err;
   logic          w_sync_q;

   m_sync2 u_sync (
      .i_clk   (clock),
      .i_rst_n (resetl),
      .i_d     (q_in),
      .o_q     (w_sync_q)
   );

   always_ff @(posedge clock or negedge resetl) begin
      if (!resetl) begin
         // Reset holds the latch cleared: r_l low, s_l high.
         r_state <= INIT;
         r_cnt   <= '0;
         r_cur   <= 1'b0;
         r_tgt   <= 1'b0;
         r_init  <= 1'b1;
         r_s_l   <= STROBE_OFF;
         r_r_l   <= STROBE_ON;
         r_busy  <= 1'b1;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            INIT: begin
               if (r_cnt == C_PW) begin
                  r_state <= POST;
                  r_cnt   <= '0;
                  r_r_l   <= STROBE_OFF;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (req != r_cur) begin
                  r_state <= PRE;
                  r_cnt   <= '0;
                  r_tgt   <= req;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            PRE: begin
               if (r_cnt == C_DEAD) begin
                  r_state <= PULSE;
                  r_cnt   <= '0;
                  if (r_tgt) r_s_l <= STROBE_ON;
                  else       r_r_l <= STROBE_ON;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            PULSE: begin
               if (r_cnt == C_PW) begin
                  r_state <= POST;
                  r_cnt   <= '0;
                  r_s_l   <= STROBE_OFF;
                  r_r_l   <= STROBE_OFF;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            POST: begin
               if (r_cnt == C_DEAD) begin
                  r_cnt <= '0;
                  // The reset-time clear is not verified or reported.
                  if (r_init) begin
                     r_state <= IDLE;
                     r_init  <= 1'b0;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= VERIFY;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            VERIFY: begin
               // A match wins even on the terminal cycle.
               if (w_sync_q == r_tgt) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_cur   <= r_tgt;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_cnt == C_TMO) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
                  r_cur   <= r_tgt;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
               r_s_l   <= STROBE_OFF;
               r_r_l   <= STROBE_OFF;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign s_l  = r_s_l;
   assign r_l  = r_r_l;
   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule
